register_file_banked: RTL and testbench
=======================================

# register_file_banked

Parametrised, multi-bank general-purpose register file for the Galetron datapath. It replaces the single-bank 32×32 file and adds the following:
- configurable width, depth and bank count;
- a register-0-as-zero option;
- same-cycle write forwarding to all read ports;
- a registered bank-switch for interrupt contexts;
- a post-reset clearing sweep with a `busy` flag.

It keeps the program-counter shadow register and the fixed status read port, and sits between decode/writeback and the ALU operand muxes.

## Interface

Parameters:
- `DATA_WIDTH`, 32, register width in bits.
- `ADDR_WIDTH`, 5, register address width; depth = 2^ADDR_WIDTH.
- `NUM_BANKS`, 2, number of register banks (power of two, ≥1); `BANK_W` = max(1, clog2(NUM_BANKS)).
- `PC_WIDTH`, 12, program-counter width (≤ DATA_WIDTH).
- `PC_REG`, 28, index of the PC shadow register.
- `STATUS_REG`, 30, index driven on `dataD`.
- `PC_LIMIT`, 256, the PC shadow updates only while `program_counter < PC_LIMIT`.
- `ZERO_REG0`, 0, when 1, register 0 reads as 0 and ignores writes.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `writeRegister` input 1: write enable.
- `writeAddress` input ADDR_WIDTH: write index; also the read index for `dataA`.
- `writeData` input DATA_WIDTH: write value.
- `readAddress1` input ADDR_WIDTH: read index for `dataB`.
- `readAddress2` input ADDR_WIDTH: read index for `dataC`.
- `program_counter` input PC_WIDTH: current PC.
- `bankSelect` input BANK_W: requested bank.
- `dataA`, `dataB`, `dataC`, `dataD` output DATA_WIDTH: read data.
- `activeBank` output BANK_W: currently active bank (registered).
- `busy` output 1: clearing sweep in progress.

## Operation

Two states: CLEAR and RUN.

CLEAR:
- Entered whenever `reset`=1 at a rising edge. The edge sets sweep index = 0, `activeBank`=0 and `busy`=1.
- While `reset` stays high, the index is held at 0.
- Each clock with `reset`=0 writes 0 to entry[index] in every bank, then increments the index.
- After the edge that clears index 2^ADDR_WIDTH−1, the state becomes RUN and `busy`=0.
- Writes, PC shadow updates and bank switches are ignored.
- All data outputs are forced to 0.

RUN:
- `activeBank` ← `bankSelect` on every edge.
- Reads and writes address `activeBank`, using its value before the edge.
- Regular write: if `writeRegister`=1, `bank[active][writeAddress]` ← `writeData`. The write is suppressed when `ZERO_REG0`=1 and `writeAddress`=0.
- PC shadow: if `program_counter < PC_LIMIT`, `bank[active][PC_REG]` ← `program_counter` zero-extended to DATA_WIDTH. The PC shadow wins over a regular write to `PC_REG` in the same cycle.
- Next value (`nv`) of an entry is the value that entry will hold after the coming edge, per the two rules above.
- `dataA`/`dataB`/`dataC` read from the active bank at their addresses. `dataD` reads from the active bank at `STATUS_REG`.
- Forwarding: if an addressed entry is written this cycle (regular or PC shadow), the output shows `nv` combinationally instead of the stored value.
- When `ZERO_REG0`=1, address 0 reads 0 regardless.
- Banks not active are untouched.

## Timing

- Reset values: `busy`=1, `activeBank`=0, `dataA`–`dataD`=0. All entries are 0 exactly 2^ADDR_WIDTH cycles after `reset` falls; `busy` falls on that same edge.
- Read latency is 0 cycles; forwarding is combinational from the write inputs.
- Write latency is 1 edge.
- A bank switch requested in cycle n takes effect for reads and writes in cycle n+1. A write in cycle n goes to the old bank.
- `reset` asserted mid-sweep or mid-run restarts CLEAR at index 0; partial writes are discarded.
- `program_counter` ≥ `PC_LIMIT`: `PC_REG` holds its value and is writable by regular writes.
- A simultaneous regular write and PC shadow to `PC_REG`: the stored value and the forwarded value both equal the zero-extended PC.

## Test plan

- Reset for 2 cycles, then release:
  - `busy`=1 for exactly 32 cycles, then 0.
  - All reads return 0 in both banks.
  - `activeBank`=0.
- Write r5=0xDEADBEEF with `readAddress1`=5 in the same cycle:
  - `dataB`=0xDEADBEEF combinationally.
  - Next cycle, with write disabled, `dataB` still reads 0xDEADBEEF.
- `program_counter`=0x0A5 with a regular write r28=0x1234:
  - `dataC`(addr 28)=0x000000A5 both same cycle and after.
  - With PC=0x100, write r28=0x1234 and read back 0x1234.
- Bank isolation:
  - Write r3=7 in bank 0, set `bankSelect`=1, write r3=9.
  - `activeBank` changes one cycle after the request.
  - Bank 1 r3 reads 9; switch back and bank 0 r3 reads 7.
- Status port: write r30=0x55 and check `dataD`=0x55. With `ZERO_REG0`=1, write r0=0xFF and check r0 reads 0.
- Mid-run reset after 10 writes:
  - Sweep restarts and `busy` is high for 32 cycles.
  - Every previously written register reads 0.

Source files
------------

// File: rtl/register_file_banked.sv
// Banked general-purpose register file: per-context banks, PC shadow register, status read port,
// same-cycle write forwarding and a post-reset clearing sweep reported on busy.
module register_file_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BANKS  = 2,
    parameter int PC_WIDTH   = 12,
    parameter int PC_REG     = 28,
    parameter int STATUS_REG = 30,
    parameter int PC_LIMIT   = 256,
    parameter bit ZERO_REG0  = 1'b0,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeRegister,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddress1,
    input  logic [ADDR_WIDTH-1:0] readAddress2,
    input  logic [PC_WIDTH-1:0]   program_counter,
    input  logic [BANK_W-1:0]     bankSelect,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB,
    output logic [DATA_WIDTH-1:0] dataC,
    output logic [DATA_WIDTH-1:0] dataD,
    output logic [BANK_W-1:0]     activeBank,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR     = ADDR_WIDTH'(PC_REG);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(STATUS_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] PC_LIM_EXT  = DATA_WIDTH'(PC_LIMIT);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [BANK_W-1:0]     r_bank;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][DEPTH];

    logic                  w_run;
    logic                  w_reg_wr;
    logic                  w_pc_wr;
    logic [DATA_WIDTH-1:0] w_pc_ext;

    // Value an entry will hold after the coming edge; what a forwarded read must show.
    function automatic logic [DATA_WIDTH-1:0] next_value(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  run,
        input logic                  reg_wr,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic                  pc_wr,
        input logic [DATA_WIDTH-1:0] pc_ext
    );
        logic [DATA_WIDTH-1:0] v;
        v = stored;
        if (reg_wr && (addr == waddr))
            v = wdata;
        if (pc_wr && (addr == PC_ADDR))
            v = pc_ext;
        if (!run || (ZERO_REG0 && (addr == '0)))
            v = '0;
        return v;
    endfunction

    assign w_run    = (r_state == ST_RUN);
    assign w_pc_ext = DATA_WIDTH'(program_counter);
    assign w_pc_wr  = w_run && (w_pc_ext < PC_LIM_EXT);
    assign w_reg_wr = w_run && writeRegister && !(ZERO_REG0 && (writeAddress == '0));

    // Control: CLEAR sweeps the index, RUN tracks the requested bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_bank  <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == ST_CLEAR) begin
            r_idx <= r_idx + ADDR_WIDTH'(1);
            if (r_idx == LAST_ADDR) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
            end
        end else begin
            r_bank <= bankSelect;
        end
    end

    // Storage: PC shadow is assigned last so it overrides a regular write to PC_REG.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                for (int b = 0; b < NUM_BANKS; b++)
                    r_mem[b][r_idx] <= '0;
            end else begin
                if (w_reg_wr)
                    r_mem[r_bank][writeAddress] <= writeData;
                if (w_pc_wr)
                    r_mem[r_bank][PC_ADDR] <= w_pc_ext;
            end
        end
    end

    always_comb begin
        dataA = next_value(writeAddress, r_mem[r_bank][writeAddress], w_run,
                           w_reg_wr, writeAddress, writeData, w_pc_wr, w_pc_ext);
        dataB = next_value(readAddress1, r_mem[r_bank][readAddress1], w_run,
                           w_reg_wr, writeAddress, writeData, w_pc_wr, w_pc_ext);
        dataC = next_value(readAddress2, r_mem[r_bank][readAddress2], w_run,
                           w_reg_wr, writeAddress, writeData, w_pc_wr, w_pc_ext);
        dataD = next_value(STATUS_ADDR, r_mem[r_bank][STATUS_ADDR], w_run,
                           w_reg_wr, writeAddress, writeData, w_pc_wr, w_pc_ext);
    end

    assign activeBank = r_bank;
    assign busy       = r_busy;

endmodule

// File: tb/tb_register_file_banked.sv
// Directed bench for register_file_banked: reset sweep, forwarding, PC shadow, banking, status, zero reg.
module tb_register_file_banked;

    logic        clock = 1'b0;
    logic        reset;
    logic        writeRegister;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [4:0]  readAddress1;
    logic [4:0]  readAddress2;
    logic [11:0] program_counter;
    logic [0:0]  bankSelect;
    logic [31:0] dataA, dataB, dataC, dataD;
    logic [0:0]  activeBank;
    logic        busy;
    logic [31:0] z_dataA, z_dataB, z_dataC, z_dataD;
    logic [0:0]  z_activeBank;
    logic        z_busy;

    always #5 clock = ~clock;

    register_file_banked #(.ZERO_REG0(1'b0)) u_dut (
        .clock(clock), .reset(reset), .writeRegister(writeRegister),
        .writeAddress(writeAddress), .writeData(writeData),
        .readAddress1(readAddress1), .readAddress2(readAddress2),
        .program_counter(program_counter), .bankSelect(bankSelect),
        .dataA(dataA), .dataB(dataB), .dataC(dataC), .dataD(dataD),
        .activeBank(activeBank), .busy(busy)
    );

    register_file_banked #(.ZERO_REG0(1'b1)) u_dut_z (
        .clock(clock), .reset(reset), .writeRegister(writeRegister),
        .writeAddress(writeAddress), .writeData(writeData),
        .readAddress1(readAddress1), .readAddress2(readAddress2),
        .program_counter(program_counter), .bankSelect(bankSelect),
        .dataA(z_dataA), .dataB(z_dataB), .dataC(z_dataC), .dataD(z_dataD),
        .activeBank(z_activeBank), .busy(z_busy)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [11:0] pc;
        logic        bs;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
        logic [31:0] ed;
        logic        ebank;
    } vec_t;

    vec_t vecs [15];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //                 we  wa     wd            ra1    ra2    pc       bs   A             B             C             D          bank
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  12'h100, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,     1'b0};
        vecs[1]  = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd28, 12'h100, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,     1'b0};
        vecs[2]  = '{1'b1, 5'd28, 32'h1234,     5'd0,  5'd28, 12'h0A5, 1'b0, 32'hA5,       32'h0,        32'hA5,       32'h0,     1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd28, 12'h100, 1'b0, 32'h0,        32'h0,        32'hA5,       32'h0,     1'b0};
        vecs[4]  = '{1'b1, 5'd28, 32'h1234,     5'd0,  5'd28, 12'h100, 1'b0, 32'h1234,     32'h0,        32'h1234,     32'h0,     1'b0};
        vecs[5]  = '{1'b0, 5'd1,  32'h0,        5'd0,  5'd28, 12'h100, 1'b0, 32'h0,        32'h0,        32'h1234,     32'h0,     1'b0};
        vecs[6]  = '{1'b1, 5'd3,  32'h7,        5'd3,  5'd28, 12'h100, 1'b1, 32'h7,        32'h7,        32'h1234,     32'h0,     1'b0};
        vecs[7]  = '{1'b1, 5'd3,  32'h9,        5'd3,  5'd5,  12'h100, 1'b1, 32'h9,        32'h9,        32'h0,        32'h0,     1'b1};
        vecs[8]  = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd28, 12'h100, 1'b0, 32'h9,        32'h9,        32'h0,        32'h0,     1'b1};
        vecs[9]  = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd5,  12'h100, 1'b0, 32'h7,        32'h7,        32'hDEADBEEF, 32'h0,     1'b0};
        vecs[10] = '{1'b1, 5'd30, 32'h55,       5'd30, 5'd3,  12'h100, 1'b0, 32'h55,       32'h55,       32'h7,        32'h55,    1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd28, 12'h100, 1'b0, 32'h0,        32'h55,       32'h1234,     32'h55,    1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd28, 12'h0FF, 1'b0, 32'h0,        32'hDEADBEEF, 32'hFF,       32'h55,    1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd28, 12'h100, 1'b0, 32'h0,        32'hDEADBEEF, 32'hFF,       32'h55,    1'b0};
        vecs[14] = '{1'b1, 5'd28, 32'hABCD,     5'd28, 5'd30, 12'h100, 1'b0, 32'hABCD,     32'hABCD,     32'h55,       32'h55,    1'b0};

        reset = 1'b1; writeRegister = 1'b0; writeAddress = '0; writeData = '0;
        readAddress1 = '0; readAddress2 = '0; program_counter = 12'h100; bankSelect = '0;
        tick();
        tick();
        chk("reset_busy", {31'b0, busy}, 32'h1);
        chk("reset_bank", {31'b0, activeBank}, 32'h0);
        chk("reset_dataA", dataA, 32'h0);
        chk("reset_dataD", dataD, 32'h0);
        chk("reset_busy_z", {31'b0, z_busy}, 32'h1);

        // Writes and bank switches during the sweep must be ignored.
        reset = 1'b0; writeRegister = 1'b1; writeAddress = 5'd31; writeData = 32'hAAAA5555;
        readAddress1 = 5'd31; bankSelect = 1'b1; program_counter = 12'h010;
        #1;
        chk("sweep_dataA_forced0", dataA, 32'h0);
        chk("sweep_dataB_forced0", dataB, 32'h0);
        sweep_len(cnt);
        chk("sweep_busy_cycles", cnt, 32'd32);
        chk("sweep_busy_low", {31'b0, busy}, 32'h0);
        chk("sweep_bank_held", {31'b0, activeBank}, 32'h0);

        writeRegister = 1'b0; bankSelect = 1'b0; program_counter = 12'h100;
        for (int a = 0; a < 32; a++) begin
            writeAddress = 5'(a); readAddress1 = 5'(a); readAddress2 = 5'(a);
            #1;
            chk($sformatf("clr_b0_B_r%0d", a), dataB, 32'h0);
            chk($sformatf("clr_b0_C_r%0d", a), dataC, 32'h0);
        end
        bankSelect = 1'b1;
        tick();
        chk("bank1_active", {31'b0, activeBank}, 32'h1);
        for (int a = 0; a < 32; a++) begin
            readAddress1 = 5'(a);
            #1;
            chk($sformatf("clr_b1_B_r%0d", a), dataB, 32'h0);
        end
        bankSelect = 1'b0;
        tick();
        chk("bank0_active", {31'b0, activeBank}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            writeRegister = vecs[i].we; writeAddress = vecs[i].wa; writeData = vecs[i].wd;
            readAddress1 = vecs[i].ra1; readAddress2 = vecs[i].ra2;
            program_counter = vecs[i].pc; bankSelect = vecs[i].bs;
            #1;
            chk($sformatf("v%0d_dataA", i), dataA, vecs[i].ea);
            chk($sformatf("v%0d_dataB", i), dataB, vecs[i].eb);
            chk($sformatf("v%0d_dataC", i), dataC, vecs[i].ec);
            chk($sformatf("v%0d_dataD", i), dataD, vecs[i].ed);
            chk($sformatf("v%0d_bank", i), {31'b0, activeBank}, {31'b0, vecs[i].ebank});
            tick();
        end

        // Register 0: writable in the plain instance, hard-wired zero in the ZERO_REG0 one.
        writeRegister = 1'b1; writeAddress = 5'd0; writeData = 32'hFF;
        readAddress1 = 5'd0; readAddress2 = 5'd0; program_counter = 12'h100; bankSelect = 1'b0;
        #1;
        chk("r0_fwd_plain", dataA, 32'hFF);
        chk("r0_fwd_zero", z_dataA, 32'h0);
        chk("r0_fwdB_zero", z_dataB, 32'h0);
        tick();
        writeRegister = 1'b0;
        #1;
        chk("r0_stored_plain", dataB, 32'hFF);
        chk("r0_stored_zero", z_dataB, 32'h0);

        // Reset mid-run, then again mid-sweep: sweep restarts from index 0 each time.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("midsweep_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        chk("rereset_bank", {31'b0, activeBank}, 32'h0);
        reset = 1'b0;
        sweep_len(cnt);
        chk("rerun_busy_cycles", cnt, 32'd32);
        chk("rerun_busy_z", {31'b0, z_busy}, 32'h0);
        foreach (vecs[i]) begin
            if (i < 4) begin
                readAddress1 = (i == 0) ? 5'd3 : (i == 1) ? 5'd5 : (i == 2) ? 5'd28 : 5'd30;
                #1;
                chk($sformatf("post_reset_b0_r%0d", readAddress1), dataB, 32'h0);
            end
        end
        writeAddress = 5'd0;
        #1;
        chk("post_reset_r0", dataA, 32'h0);
        chk("post_reset_dataD", dataD, 32'h0);
        bankSelect = 1'b1;
        tick();
        readAddress1 = 5'd3;
        #1;
        chk("post_reset_b1_r3", dataB, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
